// File: rtl/kbd_matrix4x4.sv
// Memory-mapped 4x4 keypad: row scan, column sync, frame debounce, one key code per press.
// Define KBD_IRQ_EN to add the kbd_irq output (registered copy of avail).
module kbd_matrix4x4 #(
    parameter int unsigned SCAN_DIV     = 20000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic        kbd_clk,
    input  logic        kbdrst,
    input  logic        kbdread,
    input  logic        kbdcs,
    input  logic [1:0]  kbdaddr,
    output logic [15:0] kbdrdata,
    output logic [3:0]  row,
    input  logic [3:0]  col
`ifdef KBD_IRQ_EN
    ,
    output logic        kbd_irq
`endif
);

    localparam logic [15:0] DivLast = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DbMax   = 4'(DEBOUNCE_CNT);
    // Bit 4 set marks "no single key" (none or ghosted multi-key frame).
    localparam logic [4:0]  CandNone = 5'h10;

    typedef enum logic [0:0] {StReleased, StPressed} state_e;

    state_e      state_q, state_d;
    logic [3:0]  col_meta_q, col_sync_q;
    logic [15:0] div_q;
    logic [1:0]  idx_q;
    logic [3:0]  row_q;
    logic [15:0] snap_q, snap_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  prev_q;
    logic [3:0]  key_q;
    logic        avail_q, over_q;
    logic [15:0] rdata_q, rdata_d;

    logic        tc, frame_done, stable, latch;
    logic [4:0]  ones;
    logic [3:0]  hit;
    logic [4:0]  cand;
    logic        rd_access, rd_key;

    assign tc         = (div_q == DivLast);
    assign frame_done = tc && (idx_q == 2'd3);
    assign rd_access  = kbdcs & kbdread;
    assign rd_key     = rd_access && (kbdaddr == 2'b00);

    // Snapshot including the row slot being sampled this cycle.
    always_comb begin
        snap_d = snap_q;
        if (tc) begin
            snap_d[4*idx_q +: 4] = ~col_sync_q;
        end
    end

    always_comb begin
        ones = '0;
        hit  = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
        cand = (ones == 5'd1) ? {1'b0, hit} : CandNone;
    end

    always_comb begin
        if (cand == prev_q) begin
            cnt_d = (cnt_q >= DbMax) ? DbMax : cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd1;
        end
        stable = frame_done && (cnt_d == DbMax);
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (stable && !cand[4]) begin
                    latch   = 1'b1;
                    state_d = StPressed;
                end
            end
            StPressed: begin
                if (stable && cand[4]) begin
                    state_d = StReleased;
                end
            end
            default: state_d = StReleased;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (rd_access) begin
            case (kbdaddr)
                2'b00:   rdata_d = {12'h000, key_q};
                2'b10:   rdata_d = {13'h0000, (state_q == StPressed), over_q, avail_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge kbd_clk or posedge kbdrst) begin
        if (kbdrst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
            div_q      <= '0;
            idx_q      <= '0;
            row_q      <= 4'b1110;
            snap_q     <= '0;
        end else begin
            col_meta_q <= col;
            col_sync_q <= col_meta_q;
            snap_q     <= snap_d;
            if (tc) begin
                div_q <= '0;
                idx_q <= idx_q + 2'd1;
                row_q <= ~(4'b0001 << (idx_q + 2'd1));
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    always_ff @(posedge kbd_clk or posedge kbdrst) begin
        if (kbdrst) begin
            state_q <= StReleased;
            cnt_q   <= '0;
            prev_q  <= CandNone;
        end else begin
            state_q <= state_d;
            if (frame_done) begin
                cnt_q  <= cnt_d;
                prev_q <= cand;
            end
        end
    end

    // A new key on the same edge as a key read wins over the read-clear.
    always_ff @(posedge kbd_clk or posedge kbdrst) begin
        if (kbdrst) begin
            key_q   <= '0;
            avail_q <= 1'b0;
            over_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (latch) begin
                key_q   <= cand[3:0];
                over_q  <= avail_q;
                avail_q <= 1'b1;
            end else if (rd_key) begin
                avail_q <= 1'b0;
                over_q  <= 1'b0;
            end
        end
    end

    assign kbdrdata = rdata_q;
    assign row      = row_q;

`ifdef KBD_IRQ_EN
    logic irq_q;

    always_ff @(posedge kbd_clk or posedge kbdrst) begin
        if (kbdrst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= avail_q;
        end
    end

    assign kbd_irq = irq_q;
`endif

endmodule

// File: tb/tb_kbd_matrix4x4.sv
// Bench for kbd_matrix4x4: physical keypad model plus a frame-level reference of the register file.
module tb_kbd_matrix4x4;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 2;
    localparam int          FRAME    = 16;

    logic        kbd_clk = 1'b0;
    logic        kbdrst;
    logic        kbdread;
    logic        kbdcs;
    logic [1:0]  kbdaddr;
    logic [15:0] kbdrdata;
    logic [3:0]  row;
    logic [3:0]  col;
`ifdef KBD_IRQ_EN
    logic        kbd_irq;
`endif

    logic [15:0] keys;
    int          n_cmp;
    int          n_bad;

    // Reference model state
    int          m_n;
    logic [15:0] m_fkeys;
    logic [3:0]  m_key;
    logic        m_avail, m_over, m_held, m_irq;
    int          m_prev, m_cnt;
    logic [15:0] m_rdata;

    kbd_matrix4x4 #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB)
    ) dut (
        .kbd_clk  (kbd_clk),
        .kbdrst   (kbdrst),
        .kbdread  (kbdread),
        .kbdcs    (kbdcs),
        .kbdaddr  (kbdaddr),
        .kbdrdata (kbdrdata),
        .row      (row),
        .col      (col)
`ifdef KBD_IRQ_EN
        ,
        .kbd_irq  (kbd_irq)
`endif
    );

    always #5 kbd_clk = ~kbd_clk;

    // Pressed switch shorts its column to the row line when that row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_fkeys = '0; m_key = '0; m_avail = 0; m_over = 0; m_held = 0;
        m_irq = 0; m_prev = -1; m_cnt = 0; m_rdata = '0;
    endtask

    task automatic model_tick(input logic acc, input logic [1:0] a);
        int   cand;
        int   ones;
        logic latch;
        m_n++;
        if (m_n % FRAME == 1) m_fkeys = keys;
        m_irq = m_avail;
        if (acc) begin
            case (a)
                2'b00:   m_rdata = {12'h000, m_key};
                2'b10:   m_rdata = {13'h0000, m_held, m_over, m_avail};
                default: m_rdata = '0;
            endcase
        end else begin
            m_rdata = '0;
        end
        latch = 1'b0;
        if (m_n % FRAME == 0) begin
            ones = $countones(m_fkeys);
            cand = -1;
            if (ones == 1) begin
                for (int i = 0; i < 16; i++) if (m_fkeys[i]) cand = i;
            end
            if (cand == m_prev) m_cnt = (m_cnt + 1 > DEB) ? DEB : m_cnt + 1;
            else m_cnt = 1;
            m_prev = cand;
            if (m_cnt == DEB) begin
                if (!m_held && cand >= 0) begin
                    latch = 1'b1;
                    m_key = 4'(cand);
                end else if (m_held && cand < 0) begin
                    m_held = 0;
                end
            end
        end
        if (latch) begin
            m_over  = m_avail;
            m_avail = 1;
            m_held  = 1;
        end else if (acc && a == 2'b00) begin
            m_avail = 0;
            m_over  = 0;
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at the following negedge.
    task automatic cycle(input logic cs, input logic rd, input logic [1:0] a);
        logic [3:0] exp_row;
        kbdcs = cs; kbdread = rd; kbdaddr = a;
        @(posedge kbd_clk);
        model_tick(cs & rd, a);
        @(negedge kbd_clk);
        kbdcs = 1'b0; kbdread = 1'b0;
        exp_row = ~(4'b0001 << ((m_n / 4) % 4));
        check_eq("rdata", kbdrdata, m_rdata);
        check_eq("row", {12'h000, row}, {12'h000, exp_row});
`ifdef KBD_IRQ_EN
        check_eq("irq", {15'h0, kbd_irq}, {15'h0, m_irq});
`endif
    endtask

    task automatic align();
        while (m_n % FRAME != 0) cycle(1'b0, 1'b0, 2'b00);
    endtask

    // mode 0: no reads, 1: random bus traffic, 2: status read every cycle (must be zero)
    task automatic run_frames(input logic [15:0] mask, input int nf, input int mode);
        align();
        keys = mask;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < FRAME; c++) begin
                if (mode == 1 && $urandom_range(2) == 0) begin
                    cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 2'($urandom_range(3)));
                end else if (mode == 2) begin
                    cycle(1'b1, 1'b1, 2'b10);
                    check_eq("multi_key_status", kbdrdata, 16'h0000);
                end else begin
                    cycle(1'b0, 1'b0, 2'b00);
                end
            end
        end
    endtask

    task automatic read_chk(input logic [1:0] a, input logic [15:0] exp, input string tag);
        cycle(1'b1, 1'b1, a);
        check_eq(tag, kbdrdata, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] m;
        int          k1, k2;
        n_cmp = 0; n_bad = 0;
        kbdrst = 1'b1; kbdcs = 1'b0; kbdread = 1'b0; kbdaddr = 2'b00; keys = '0;
        model_reset();
        #1;
        check_eq("reset_row", {12'h000, row}, 16'h000E);
        check_eq("reset_rdata", kbdrdata, 16'h0000);
        repeat (2) @(posedge kbd_clk);
        @(negedge kbd_clk);
        kbdrst = 1'b0;

        // Idle scan and empty status
        run_frames(16'h0000, 7, 0);
        read_chk(2'b10, 16'h0000, "idle_status");

        // Key 6 held: one event, read clears avail
        run_frames(16'h0040, 5, 0);
        read_chk(2'b10, 16'h0005, "k6_status");
        read_chk(2'b00, 16'h0006, "k6_value");
        read_chk(2'b10, 16'h0004, "k6_status_after_read");

        // Unread key 6 then key 9: overrun
        run_frames(16'h0000, 3, 0);
        run_frames(16'h0040, 3, 0);
        run_frames(16'h0000, 3, 0);
        run_frames(16'h0200, 3, 0);
        read_chk(2'b10, 16'h0007, "overrun_status");
        read_chk(2'b00, 16'h0009, "k9_value");
        run_frames(16'h0000, 3, 0);
        read_chk(2'b10, 16'h0000, "released_status");

        // Two keys together are rejected
        run_frames(16'h0021, 6, 2);

        // Bouncing key 0, then steady
        for (int i = 0; i < 6; i++) run_frames((i % 2 == 0) ? 16'h0001 : 16'h0000, 1, 0);
        read_chk(2'b10, 16'h0000, "bounce_no_event");
        run_frames(16'h0001, 2, 0);
        read_chk(2'b10, 16'h0005, "k0_status");
        read_chk(2'b00, 16'h0000, "k0_value");
        run_frames(16'h0001, 3, 0);
        read_chk(2'b10, 16'h0004, "k0_once");
        run_frames(16'h0000, 3, 0);

        // Reset mid-frame with key 6 held
        run_frames(16'h0040, 2, 0);
        repeat (7) cycle(1'b0, 1'b0, 2'b00);
        read_chk(2'b10, 16'h0005, "pre_reset_status");
        kbdrst = 1'b1;
        #1;
        check_eq("midreset_row", {12'h000, row}, 16'h000E);
        check_eq("midreset_rdata", kbdrdata, 16'h0000);
`ifdef KBD_IRQ_EN
        check_eq("midreset_irq", {15'h0, kbd_irq}, 16'h0000);
`endif
        repeat (2) @(posedge kbd_clk);
        @(negedge kbd_clk);
        kbdrst = 1'b0;
        model_reset();
        run_frames(16'h0040, 3, 0);
        read_chk(2'b10, 16'h0005, "redetect_status");
        read_chk(2'b00, 16'h0006, "redetect_value");

        // Randomized key activity with random bus traffic
        for (int s = 0; s < 40; s++) begin
            m  = '0;
            k1 = $urandom_range(15);
            k2 = $urandom_range(15);
            case ($urandom_range(3))
                0:       m = '0;
                1, 2:    m[k1] = 1'b1;
                default: begin m[k1] = 1'b1; m[k2] = 1'b1; end
            endcase
            run_frames(m, $urandom_range(1, 4), 1);
        end
        align();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
